// File: rtl/ui_uart_tx_word_fifo.sv
// rtl/ui_uart_tx_word_fifo.sv - word FIFO that feeds bytes LSB-first to the UART transmit controller
//
// Buffers WORD_BYTES-wide words in a DEPTH-entry FIFO. A holding register takes the
// FIFO head and presents it one byte at a time on tx_data / tx_data_val, advancing
// on each tx_done pulse from the transmit controller.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   wr_en, wr_data word write request and data
//   full, empty    registered FIFO flags (holding register excluded)
//   fifo_count     registered word count in the FIFO
//   overflow       sticky dropped-write flag; clr_overflow clears it
//   flush          empties the FIFO; the holding register is left alone
//   tx_data_val    a byte is being presented
//   tx_data        current byte, stable until load or accepted tx_done
//   tx_done        one-clk pulse: current byte has been shifted out
//   busy           tx_data_val or FIFO not empty
module ui_uart_tx_word_fifo #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 8,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int WORD_W    = 8 * WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  input  logic              clr_overflow,
  input  logic              flush,
  output logic              tx_data_val,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;

  logic [WORD_W-1:0] hold_word;
  logic [IDX_W-1:0]  byte_idx;
  logic              hold_valid;

  logic              wr_ok;
  logic              drop;
  logic              last_done;
  logic              load;
  logic [WORD_W-1:0] head;
  logic [IDX_W-1:0]  next_idx;
  logic [WORD_W-1:0] shifted;

  // A write during flush is discarded silently; only a write against a full FIFO
  // counts as an overflow, even if a pop happens in the same cycle.
  assign wr_ok     = wr_en && !full && !flush;
  assign drop      = wr_en && full && !flush;
  assign last_done = hold_valid && tx_done && (byte_idx == LAST_IDX);
  // Load when the holding register is idle or finishing its last byte; flush wins.
  assign load      = !flush && !empty && (!hold_valid || last_done);
  assign head      = mem[rd_ptr];
  assign next_idx  = byte_idx + IDX_W'(1);
  assign shifted   = hold_word >> {next_idx, 3'b000};

  assign tx_data_val = hold_valid;
  assign busy        = hold_valid || !empty;

  always_comb begin
    count_next = fifo_count;
    if (flush) begin
      count_next = '0;
    end else if (wr_ok && !load) begin
      count_next = fifo_count + (ADDR_W+1)'(1);
    end else if (!wr_ok && load) begin
      count_next = fifo_count - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
      hold_word  <= '0;
      byte_idx   <= '0;
      hold_valid <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (load)  rd_ptr <= rd_ptr + ADDR_W'(1);
      end

      fifo_count <= count_next;
      full       <= (count_next == (ADDR_W+1)'(DEPTH));
      empty      <= (count_next == '0);

      // Set beats clear when both happen in one cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      if (load) begin
        hold_word  <= head;
        byte_idx   <= '0;
        hold_valid <= 1'b1;
        tx_data    <= head[7:0];
      end else if (hold_valid && tx_done) begin
        if (byte_idx != LAST_IDX) begin
          byte_idx <= next_idx;
          tx_data  <= shifted[7:0];
        end else begin
          hold_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ui_uart_tx_word_fifo.sv
// tb/tb_ui_uart_tx_word_fifo.sv - directed self-checking bench for ui_uart_tx_word_fifo
module tb_ui_uart_tx_word_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        empty;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        clr_overflow;
  logic        flush;
  logic        tx_data_val;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ui_uart_tx_word_fifo #(.WORD_BYTES(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .fifo_count(fifo_count), .overflow(overflow),
    .clr_overflow(clr_overflow), .flush(flush), .tx_data_val(tx_data_val),
    .tx_data(tx_data), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic drain_word(input string tag, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_val"}, tx_data_val, 1'b1);
      chk({tag, "_byte"}, tx_data, w[8*b +: 8]);
      done_pulse();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] words [6];
  logic [7:0]  b2b [8];

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0;
    flush = 1'b0; tx_done = 1'b0;
    do_reset();

    // Reset state
    chk("rst_val", tx_data_val, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);

    // Single word: latency two clocks, LSB first
    push(32'hA1B2C3D4);
    chk("sw_lat1_val", tx_data_val, 1'b0);
    chk("sw_lat1_count", fifo_count, 3'd1);
    tick();
    chk("sw_lat2_val", tx_data_val, 1'b1);
    chk("sw_b0", tx_data, 8'hD4);
    chk("sw_count0", fifo_count, 3'd0);
    done_pulse();
    chk("sw_b1", tx_data, 8'hC3);
    done_pulse();
    chk("sw_b2", tx_data, 8'hB2);
    done_pulse();
    chk("sw_b3", tx_data, 8'hA1);
    chk("sw_b3_val", tx_data_val, 1'b1);
    done_pulse();
    chk("sw_end_val", tx_data_val, 1'b0);
    chk("sw_end_busy", busy, 1'b0);

    // Back-to-back words: no gap at the word boundary
    b2b[0] = 8'h44; b2b[1] = 8'h33; b2b[2] = 8'h22; b2b[3] = 8'h11;
    b2b[4] = 8'h88; b2b[5] = 8'h77; b2b[6] = 8'h66; b2b[7] = 8'h55;
    push(32'h11223344);
    push(32'h55667788);
    chk("b2b_count1", fifo_count, 3'd1);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_val", tx_data_val, 1'b1);
      chk("b2b_byte", tx_data, b2b[i]);
      if (i == 3) chk("b2b_count_pre", fifo_count, 3'd1);
      if (i == 4) chk("b2b_count_post", fifo_count, 3'd0);
      done_pulse();
    end
    chk("b2b_end_val", tx_data_val, 1'b0);

    // Full and overflow with DEPTH=4
    words[0] = 32'h10111213; words[1] = 32'h20212223; words[2] = 32'h30313233;
    words[3] = 32'h40414243; words[4] = 32'h50515253; words[5] = 32'h60616263;
    for (int i = 0; i < 6; i++) push(words[i]);
    chk("ovf_full", full, 1'b1);
    chk("ovf_count", fifo_count, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_hold", tx_data, 8'h13);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 5; i++) drain_word("ovf_drain", words[i]);
    chk("ovf_end_val", tx_data_val, 1'b0);
    chk("ovf_end_empty", empty, 1'b1);

    // Concurrent write and pop on last-byte tx_done
    push(32'hAAAA0001);
    push(32'hBBBB0002);
    push(32'hCCCC0003);
    chk("cc_count_pre", fifo_count, 3'd2);
    done_pulse(); done_pulse(); done_pulse();
    chk("cc_last_byte", tx_data, 8'hAA);
    tx_done = 1'b1; wr_en = 1'b1; wr_data = 32'hDDDD0004;
    tick();
    tx_done = 1'b0; wr_en = 1'b0;
    chk("cc_count_same", fifo_count, 3'd2);
    chk("cc_val", tx_data_val, 1'b1);
    drain_word("cc_w2", 32'hBBBB0002);
    drain_word("cc_w3", 32'hCCCC0003);
    drain_word("cc_w4", 32'hDDDD0004);
    chk("cc_end_val", tx_data_val, 1'b0);

    // Flush mid-word, with a concurrent write that must not set overflow
    push(32'h01020304);
    push(32'h05060708);
    push(32'h090A0B0C);
    push(32'h0D0E0F10);
    chk("fl_count_pre", fifo_count, 3'd3);
    done_pulse();
    chk("fl_byte1", tx_data, 8'h03);
    flush = 1'b1; wr_en = 1'b1; wr_data = 32'hDEADBEEF;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("fl_count", fifo_count, 3'd0);
    chk("fl_empty", empty, 1'b1);
    chk("fl_ovf", overflow, 1'b0);
    chk("fl_hold_byte", tx_data, 8'h03);
    done_pulse();
    chk("fl_byte2", tx_data, 8'h02);
    done_pulse();
    chk("fl_byte3", tx_data, 8'h01);
    chk("fl_byte3_val", tx_data_val, 1'b1);
    done_pulse();
    chk("fl_end_val", tx_data_val, 1'b0);
    chk("fl_end_busy", busy, 1'b0);

    // Reset mid-word
    push(32'h77665544);
    push(32'h33221100);
    push(32'hFFEEDDCC);
    chk("rm_count_pre", fifo_count, 3'd2);
    chk("rm_val_pre", tx_data_val, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_val", tx_data_val, 1'b0);
    chk("rm_count", fifo_count, 3'd0);
    chk("rm_ovf", overflow, 1'b0);
    chk("rm_data", tx_data, 8'h00);
    done_pulse();
    chk("rm_spur_val", tx_data_val, 1'b0);
    chk("rm_spur_data", tx_data, 8'h00);
    chk("rm_spur_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
